// File: rtl/mem_pkg.sv
`default_nettype none
//==============================================================================
// Module   : mem_pkg
// Desc     : Shared constants, instruction field offsets and access-size
//            decode helpers for the memory address generation unit.
// Revision : 1.0 - initial release
//==============================================================================
package mem_pkg;

    // Major opcodes handled as memory operations
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    // funct3 encodings for loads/stores
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Decoded instruction field positions (LSB and width)
    localparam int FLD_OPC_LSB = 65;
    localparam int FLD_OPC_W   = 7;
    localparam int FLD_F3_LSB  = 62;
    localparam int FLD_F3_W    = 3;
    localparam int FLD_RS1_LSB = 45;
    localparam int FLD_RS2_LSB = 40;
    localparam int FLD_REG_W   = 5;
    localparam int FLD_IMM_LSB = 3;
    localparam int FLD_IMM_W   = 32;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } acc_size_e;

    // Stores only support signed widths; loads add the unsigned byte/half forms
    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        if (is_store)
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    // Low two funct3 bits encode the access width for all legal encodings
    function automatic acc_size_e f3_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return BYTE;
            2'b01:   return HALF;
            default: return WORD;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_agu_stage.sv
`default_nettype none
//==============================================================================
// Module   : mem_agu_stage
// Desc     : One valid + payload pipeline register with enable and clear.
//            Clear kills the valid bit only; payload is don't-care when invalid.
// Revision : 1.0 - initial release
//==============================================================================
module mem_agu_stage
    import mem_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         valid_q;
    logic [W-1:0] data_q;

    // Stage register: reset zeroes everything, clear wins over enable
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (clr_i) begin
            valid_q <= 1'b0;
        end else if (en_i) begin
            valid_q <= valid_i;
            data_q  <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule
`default_nettype wire

// File: rtl/mem_agu.sv
`default_nettype none
//==============================================================================
// Module   : mem_agu
// Desc     : Load/store address generation. Computes the virtual address at
//            issue, raises a single L1D request the cycle after acceptance and
//            delivers the decoded result LAT cycles later through a lock-step
//            pipeline of valid/payload stages.
// Revision : 1.0 - initial release
//==============================================================================
module mem_agu
    import mem_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int INST_W = 72,
    parameter int LAT    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 iq_valid_i,
    output logic                 iq_ready_o,
    input  logic [XLEN-1:0]      iq_addr_i,
    input  logic [INST_W-1:0]    iq_inst_i,
    input  logic [NREG*XLEN-1:0] reg_rdata_i,
    input  logic                 flush_i,
    output logic                 dc_req_o,
    input  logic                 dc_gnt_i,
    output logic                 dc_we_o,
    output logic [XLEN-1:0]      dc_addr_o,
    output logic [XLEN/8-1:0]    dc_be_o,
    output logic [XLEN-1:0]      dc_wdata_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [XLEN-1:0]      out_addr_o,
    output logic [INST_W-1:0]    out_inst_o,
    output logic [XLEN-1:0]      out_vaddr_o,
    output logic                 out_misalign_o,
    output logic                 out_illegal_o
);

    localparam int BE_W   = XLEN / 8;
    localparam int LANE_W = $clog2(BE_W);

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [INST_W-1:0] inst;
        logic [XLEN-1:0]   vaddr;
        logic              mis;
        logic              ill;
    } entry_t;

    localparam int EW = $bits(entry_t);

    // ---------------- issue-side decode ----------------
    logic [FLD_OPC_W-1:0] w_opc;
    logic [FLD_F3_W-1:0]  w_f3;
    logic [FLD_REG_W-1:0] w_rs1_idx;
    logic [FLD_REG_W-1:0] w_rs2_idx;
    logic [XLEN-1:0]      w_rs1_val;
    logic [XLEN-1:0]      w_rs2_val;
    logic [XLEN-1:0]      w_imm;
    logic [XLEN-1:0]      w_vaddr;
    logic                 w_is_st;
    logic                 w_is_mem;
    logic                 w_f3_ok;
    logic                 w_mis;
    logic                 w_ill;
    logic                 w_memreq;
    acc_size_e            w_size;
    logic [BE_W-1:0]      w_be;
    logic [XLEN-1:0]      w_wdata;
    logic                 w_adv;
    entry_t               w_new;
    entry_t               w_tail;

    assign w_opc     = iq_inst_i[FLD_OPC_LSB +: FLD_OPC_W];
    assign w_f3      = iq_inst_i[FLD_F3_LSB  +: FLD_F3_W];
    assign w_rs1_idx = iq_inst_i[FLD_RS1_LSB +: FLD_REG_W];
    assign w_rs2_idx = iq_inst_i[FLD_RS2_LSB +: FLD_REG_W];
    assign w_imm     = XLEN'($signed(iq_inst_i[FLD_IMM_LSB +: FLD_IMM_W]));
    assign w_rs1_val = reg_rdata_i[w_rs1_idx * XLEN +: XLEN];
    assign w_rs2_val = reg_rdata_i[w_rs2_idx * XLEN +: XLEN];
    assign w_vaddr   = w_rs1_val + w_imm;

    // Classify the incoming op and build byte enables / store data lanes
    always_comb begin
        w_is_st  = (w_opc == OPC_STORE);
        w_is_mem = w_is_st || (w_opc == OPC_LOAD);
        w_f3_ok  = f3_legal(w_is_st, w_f3);
        w_size   = f3_size(w_f3);
        w_ill    = w_is_mem && !w_f3_ok;
        w_mis    = w_is_mem && w_f3_ok &&
                   (((w_size == HALF) && w_vaddr[0]) ||
                    ((w_size == WORD) && (w_vaddr[1:0] != 2'b00)));
        w_memreq = w_is_mem && w_f3_ok && !w_mis;
        w_be     = '0;
        w_wdata  = '0;
        case (w_size)
            BYTE: begin
                w_be = BE_W'(4'b0001) << w_vaddr[LANE_W-1:0];
                if (w_is_st) w_wdata = {BE_W{w_rs2_val[7:0]}};
            end
            HALF: begin
                w_be = BE_W'(4'b0011) << w_vaddr[LANE_W-1:0];
                if (w_is_st) w_wdata = {(XLEN/16){w_rs2_val[15:0]}};
            end
            default: begin
                w_be = BE_W'(4'b1111) << w_vaddr[LANE_W-1:0];
                if (w_is_st) w_wdata = {(XLEN/32){w_rs2_val[31:0]}};
            end
        endcase
        w_new.pc    = iq_addr_i;
        w_new.inst  = iq_inst_i;
        w_new.vaddr = w_vaddr;
        w_new.mis   = w_mis;
        w_new.ill   = w_ill;
    end

    // ---------------- lock-step pipeline ----------------
    logic [LAT-1:0] stg_valid;
    logic [EW-1:0]  stg_data [LAT];
    logic           dc_req_q;

    assign w_adv      = (!stg_valid[LAT-1] || out_ready_i) &&
                        (!dc_req_q || dc_gnt_i) && !flush_i;
    assign iq_ready_o = w_adv;

    for (genvar gi = 0; gi < LAT; gi++) begin : g_stage
        if (gi == 0) begin : g_head
            mem_agu_stage #(.W(EW)) u_stage (
                .clk     (clk),
                .rst     (rst),
                .en_i    (w_adv),
                .clr_i   (flush_i),
                .valid_i (iq_valid_i),
                .data_i  (w_new),
                .valid_o (stg_valid[gi]),
                .data_o  (stg_data[gi])
            );
        end else begin : g_body
            mem_agu_stage #(.W(EW)) u_stage (
                .clk     (clk),
                .rst     (rst),
                .en_i    (w_adv),
                .clr_i   (flush_i),
                .valid_i (stg_valid[gi-1]),
                .data_i  (stg_data[gi-1]),
                .valid_o (stg_valid[gi]),
                .data_o  (stg_data[gi])
            );
        end
    end

    assign w_tail         = stg_data[LAT-1];
    assign out_valid_o    = stg_valid[LAT-1];
    assign out_addr_o     = w_tail.pc;
    assign out_inst_o     = w_tail.inst;
    assign out_vaddr_o    = w_tail.vaddr;
    assign out_misalign_o = stg_valid[LAT-1] && w_tail.mis;
    assign out_illegal_o  = stg_valid[LAT-1] && w_tail.ill;

    // ---------------- L1D request port ----------------
    logic              dc_req_d;
    logic              dc_we_q,    dc_we_d;
    logic [XLEN-1:0]   dc_addr_q,  dc_addr_d;
    logic [BE_W-1:0]   dc_be_q,    dc_be_d;
    logic [XLEN-1:0]   dc_wdata_q, dc_wdata_d;

    // Request is loaded when a legal aligned op advances in, held until granted,
    // and its fields are zeroed whenever no request is outstanding
    always_comb begin
        dc_req_d   = dc_req_q;
        dc_we_d    = dc_we_q;
        dc_addr_d  = dc_addr_q;
        dc_be_d    = dc_be_q;
        dc_wdata_d = dc_wdata_q;
        if (flush_i || (!w_adv && dc_gnt_i) || (w_adv && !(iq_valid_i && w_memreq))) begin
            dc_req_d   = 1'b0;
            dc_we_d    = 1'b0;
            dc_addr_d  = '0;
            dc_be_d    = '0;
            dc_wdata_d = '0;
        end else if (w_adv) begin
            dc_req_d   = 1'b1;
            dc_we_d    = w_is_st;
            dc_addr_d  = w_vaddr;
            dc_be_d    = w_be;
            dc_wdata_d = w_wdata;
        end
    end

    // Request register; reset drops any outstanding request immediately
    always_ff @(posedge clk) begin
        if (rst) begin
            dc_req_q   <= 1'b0;
            dc_we_q    <= 1'b0;
            dc_addr_q  <= '0;
            dc_be_q    <= '0;
            dc_wdata_q <= '0;
        end else begin
            dc_req_q   <= dc_req_d;
            dc_we_q    <= dc_we_d;
            dc_addr_q  <= dc_addr_d;
            dc_be_q    <= dc_be_d;
            dc_wdata_q <= dc_wdata_d;
        end
    end

    assign dc_req_o   = dc_req_q;
    assign dc_we_o    = dc_we_q;
    assign dc_addr_o  = dc_addr_q;
    assign dc_be_o    = dc_be_q;
    assign dc_wdata_o = dc_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_agu.sv
`default_nettype none
//==============================================================================
// Module   : tb_mem_agu
// Desc     : Self-checking bench for mem_agu: table of load/store vectors with
//            a scoreboard for L1D requests and pipeline outputs, plus directed
//            grant-stall, output-stall, flush and reset sequences.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
module tb_mem_agu;

    localparam int XLEN   = 32;
    localparam int NREG   = 32;
    localparam int INST_W = 72;
    localparam int LAT    = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 iq_valid_i = 1'b0;
    logic                 iq_ready_o;
    logic [XLEN-1:0]      iq_addr_i = '0;
    logic [INST_W-1:0]    iq_inst_i = '0;
    logic [NREG*XLEN-1:0] regs;
    logic                 flush_i = 1'b0;
    logic                 dc_req_o;
    logic                 dc_gnt_i = 1'b1;
    logic                 dc_we_o;
    logic [XLEN-1:0]      dc_addr_o;
    logic [XLEN/8-1:0]    dc_be_o;
    logic [XLEN-1:0]      dc_wdata_o;
    logic                 out_valid_o;
    logic                 out_ready_i = 1'b1;
    logic [XLEN-1:0]      out_addr_o;
    logic [INST_W-1:0]    out_inst_o;
    logic [XLEN-1:0]      out_vaddr_o;
    logic                 out_misalign_o;
    logic                 out_illegal_o;

    always #5 clk = ~clk;

    mem_agu #(.XLEN(XLEN), .NREG(NREG), .INST_W(INST_W), .LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .iq_valid_i(iq_valid_i), .iq_ready_o(iq_ready_o),
        .iq_addr_i(iq_addr_i), .iq_inst_i(iq_inst_i),
        .reg_rdata_i(regs), .flush_i(flush_i),
        .dc_req_o(dc_req_o), .dc_gnt_i(dc_gnt_i), .dc_we_o(dc_we_o),
        .dc_addr_o(dc_addr_o), .dc_be_o(dc_be_o), .dc_wdata_o(dc_wdata_o),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_addr_o(out_addr_o), .out_inst_o(out_inst_o),
        .out_vaddr_o(out_vaddr_o), .out_misalign_o(out_misalign_o),
        .out_illegal_o(out_illegal_o)
    );

    typedef struct {
        logic [6:0]  opc;   logic [2:0]  f3;
        logic [4:0]  rs1;   logic [31:0] rs1v;
        logic [4:0]  rs2;   logic [31:0] rs2v;
        logic [31:0] imm;   logic [31:0] pc;
        logic        dc;    logic        we;
        logic [3:0]  be;    logic [31:0] wdata;
        logic [31:0] vaddr; logic        mis;  logic ill;
    } vec_t;

    typedef struct {
        logic [31:0] pc; logic [71:0] inst; logic [31:0] vaddr;
        logic mis; logic ill; int cyc; bit lat;
    } out_exp_t;

    typedef struct {
        logic [31:0] addr; logic [3:0] be; logic we; logic [31:0] wdata;
        int cyc; bit lat;
    } dc_exp_t;

    out_exp_t out_q[$];
    dc_exp_t  dc_q[$];
    vec_t     tbl[13];
    int       cyc = 0;
    int       n_chk = 0;
    int       n_pass = 0;
    bit       chk_lat = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input bit ok, input logic [127:0] got, input logic [127:0] want);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, got, want);
    endtask

    function automatic vec_t mk(input logic [6:0] opc, input logic [2:0] f3,
                                input logic [4:0] rs1, input logic [31:0] rs1v,
                                input logic [4:0] rs2, input logic [31:0] rs2v,
                                input logic [31:0] imm, input logic [31:0] pc,
                                input logic dc, input logic we, input logic [3:0] be,
                                input logic [31:0] wdata, input logic [31:0] vaddr,
                                input logic mis, input logic ill);
        vec_t v;
        v.opc = opc; v.f3 = f3; v.rs1 = rs1; v.rs1v = rs1v; v.rs2 = rs2; v.rs2v = rs2v;
        v.imm = imm; v.pc = pc; v.dc = dc; v.we = we; v.be = be; v.wdata = wdata;
        v.vaddr = vaddr; v.mis = mis; v.ill = ill;
        return v;
    endfunction

    // Drive one instruction and wait (bounded) for acceptance; record expectations
    task automatic issue(input vec_t v);
        logic [71:0] inst;
        bit acc = 1'b0;
        inst = '0;
        inst[71:65] = v.opc; inst[64:62] = v.f3; inst[49:45] = v.rs1;
        inst[44:40] = v.rs2; inst[34:3] = v.imm; inst[2:0] = 3'b101; inst[55:50] = v.pc[7:2];
        iq_addr_i = v.pc;
        iq_inst_i = inst;
        regs[v.rs1*XLEN +: XLEN] = v.rs1v;
        regs[v.rs2*XLEN +: XLEN] = v.rs2v;
        iq_valid_i = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (iq_ready_o && !rst) begin
                acc = 1'b1;
                out_q.push_back('{pc:v.pc, inst:inst, vaddr:v.vaddr, mis:v.mis, ill:v.ill,
                                  cyc:cyc + LAT, lat:chk_lat});
                if (v.dc)
                    dc_q.push_back('{addr:v.vaddr, be:v.be, we:v.we, wdata:v.wdata,
                                     cyc:cyc + 1, lat:chk_lat});
            end
            @(posedge clk); #1;
            if (acc) break;
        end
        iq_valid_i = 1'b0;
        if (!acc) chk("issue_timeout", 1'b0, 128'(v.pc), 128'(1));
    endtask

    // Scoreboard: compare each granted request and each consumed output
    always @(negedge clk) begin
        if (rst || flush_i) begin
            out_q.delete();
            dc_q.delete();
        end else begin
            if (dc_req_o && dc_gnt_i) begin
                if (dc_q.size() == 0) begin
                    chk("dc_unexpected", 1'b0, 128'(dc_addr_o), 128'(0));
                end else begin
                    dc_exp_t d;
                    d = dc_q.pop_front();
                    chk("dc_req", (dc_addr_o == d.addr) && (dc_be_o == d.be) &&
                        (dc_we_o == d.we) && (dc_wdata_o == d.wdata) && (!d.lat || cyc == d.cyc),
                        {dc_addr_o, 27'(dc_be_o), dc_we_o, dc_wdata_o, 32'(cyc)},
                        {d.addr, 27'(d.be), d.we, d.wdata, 32'(d.cyc)});
                end
            end
            if (out_valid_o && out_ready_i) begin
                if (out_q.size() == 0) begin
                    chk("out_unexpected", 1'b0, 128'(out_addr_o), 128'(0));
                end else begin
                    out_exp_t e;
                    e = out_q.pop_front();
                    chk("out_entry", (out_addr_o == e.pc) && (out_inst_o == e.inst) &&
                        (out_vaddr_o == e.vaddr) && (out_misalign_o == e.mis) &&
                        (out_illegal_o == e.ill) && (!e.lat || cyc == e.cyc),
                        {out_addr_o, out_vaddr_o, 30'(out_misalign_o), out_illegal_o, 32'(cyc)},
                        {e.pc, e.vaddr, 30'(e.mis), e.ill, 32'(e.cyc)});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int r = 0; r < NREG; r++) regs[r*XLEN +: XLEN] = 32'hA000_0000 + 32'(r) * 32'h111;

        //         opc         f3      rs1  rs1v           rs2  rs2v           imm            pc            dc   we   be       wdata          vaddr          mis  ill
        tbl[0]  = mk(7'b0000011, 3'b010, 5,  32'h0000_1000, 7,  32'hDEAD_BEEF, 32'h0000_0008, 32'h8000_0000, 1, 0, 4'b1111, 32'h0,         32'h0000_1008, 0, 0);
        tbl[1]  = mk(7'b0100011, 3'b000, 6,  32'h0000_2003, 8,  32'h1234_56A5, 32'h0000_0000, 32'h8000_0004, 1, 1, 4'b1000, 32'hA5A5_A5A5, 32'h0000_2003, 0, 0);
        tbl[2]  = mk(7'b0000011, 3'b001, 10, 32'h0000_1000, 11, 32'h0,         32'h0000_0001, 32'h8000_0008, 0, 0, 4'b0000, 32'h0,         32'h0000_1001, 1, 0);
        tbl[3]  = mk(7'b0000011, 3'b011, 31, 32'h0000_1000, 3,  32'h0,         32'h0000_0004, 32'h8000_000C, 0, 0, 4'b0000, 32'h0,         32'h0000_1004, 0, 1);
        tbl[4]  = mk(7'b0100011, 3'b001, 1,  32'h0000_3000, 2,  32'hBEEF_1234, 32'hFFFF_FFFE, 32'h8000_0010, 1, 1, 4'b1100, 32'h1234_1234, 32'h0000_2FFE, 0, 0);
        tbl[5]  = mk(7'b0000011, 3'b100, 12, 32'h0000_0010, 13, 32'hFFFF_FFFF, 32'h0000_0001, 32'h8000_0014, 1, 0, 4'b0010, 32'h0,         32'h0000_0011, 0, 0);
        tbl[6]  = mk(7'b0100011, 3'b010, 14, 32'h0000_4000, 15, 32'h5555_AAAA, 32'h0000_0002, 32'h8000_0018, 0, 0, 4'b0000, 32'h0,         32'h0000_4002, 1, 0);
        tbl[7]  = mk(7'b0100011, 3'b100, 16, 32'h0000_4000, 17, 32'h1111_2222, 32'h0000_0000, 32'h8000_001C, 0, 0, 4'b0000, 32'h0,         32'h0000_4000, 0, 1);
        tbl[8]  = mk(7'b0110011, 3'b000, 18, 32'h0000_0100, 19, 32'h0,         32'h0000_0020, 32'h8000_0020, 0, 0, 4'b0000, 32'h0,         32'h0000_0120, 0, 0);
        tbl[9]  = mk(7'b0000011, 3'b101, 20, 32'h0000_5000, 21, 32'h0,         32'h0000_0006, 32'h8000_0024, 1, 0, 4'b1100, 32'h0,         32'h0000_5006, 0, 0);
        tbl[10] = mk(7'b0000011, 3'b010, 22, 32'hFFFF_FFFC, 23, 32'h0,         32'h0000_0008, 32'h8000_0028, 1, 0, 4'b1111, 32'h0,         32'h0000_0004, 0, 0);
        tbl[11] = mk(7'b0000011, 3'b000, 24, 32'h0000_0007, 25, 32'h0,         32'h0000_0000, 32'h8000_002C, 1, 0, 4'b1000, 32'h0,         32'h0000_0007, 0, 0);
        tbl[12] = mk(7'b0100011, 3'b010, 26, 32'h0000_6000, 27, 32'hCAFE_F00D, 32'h0000_0010, 32'h8000_0030, 1, 1, 4'b1111, 32'hCAFE_F00D, 32'h0000_6010, 0, 0);

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_dc", !dc_req_o && !dc_we_o && dc_addr_o == 0 && dc_be_o == 0 && dc_wdata_o == 0,
            {dc_req_o, dc_we_o, dc_addr_o, dc_be_o, dc_wdata_o}, 128'(0));
        chk("reset_out", !out_valid_o && !out_misalign_o && !out_illegal_o,
            {out_valid_o, out_misalign_o, out_illegal_o}, 128'(0));
        chk("reset_ready", iq_ready_o == 1'b1, 128'(iq_ready_o), 128'(1));
        @(posedge clk); #1;

        // Back-to-back table traffic, no stalls, exact latency checked
        chk_lat = 1'b1;
        for (int i = 0; i < 13; i++) issue(tbl[i]);
        repeat (LAT + 2) @(posedge clk);
        #1 chk_lat = 1'b0;

        // Grant withheld for three cycles: request held, issue blocked
        dc_gnt_i = 1'b0;
        issue(tbl[0]);
        fork
            issue(tbl[12]);
            begin
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    chk("gnt_stall_hold", dc_req_o && dc_addr_o == 32'h0000_1008 && dc_be_o == 4'b1111 && !iq_ready_o,
                        {dc_req_o, dc_addr_o, dc_be_o, iq_ready_o}, {1'b1, 32'h0000_1008, 4'b1111, 1'b0});
                    @(posedge clk); #1;
                end
                dc_gnt_i = 1'b1;
            end
        join
        repeat (LAT + 3) @(posedge clk); #1;

        // Output back-pressure with back-to-back issue
        out_ready_i = 1'b0;
        fork
            begin
                issue(tbl[0]); issue(tbl[1]); issue(tbl[5]); issue(tbl[9]);
            end
            begin
                repeat (5) @(posedge clk); #1;
                chk("out_stall_full", !iq_ready_o && out_valid_o && out_addr_o == 32'h8000_0000 && !dc_req_o,
                    {iq_ready_o, out_valid_o, out_addr_o, dc_req_o}, {1'b0, 1'b1, 32'h8000_0000, 1'b0});
                out_ready_i = 1'b1;
            end
        join
        repeat (LAT + 3) @(posedge clk); #1;

        // Flush with a pending ungranted request and a same-cycle issue
        dc_gnt_i = 1'b0;
        issue(tbl[0]);
        flush_i    = 1'b1;
        iq_valid_i = 1'b1;
        iq_addr_i  = tbl[1].pc;
        @(negedge clk);
        chk("flush_pre", dc_req_o && !iq_ready_o, {dc_req_o, iq_ready_o}, {1'b1, 1'b0});
        @(posedge clk); #1;
        flush_i = 1'b0; iq_valid_i = 1'b0; dc_gnt_i = 1'b1;
        chk("flush_clear", !dc_req_o && !out_valid_o, {dc_req_o, out_valid_o}, 128'(0));
        begin
            bit leak = 1'b0;
            for (int k = 0; k < LAT + 1; k++) begin
                @(negedge clk);
                if (dc_req_o || out_valid_o) leak = 1'b1;
            end
            chk("flush_no_leak", !leak, 128'(leak), 128'(0));
        end
        @(posedge clk); #1;

        // Reset mid-stream with an ungranted request outstanding
        issue(tbl[9]);
        issue(tbl[12]);
        dc_gnt_i = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; dc_gnt_i = 1'b1;
        chk("rst_mid_clear", !dc_req_o && !dc_we_o && dc_addr_o == 0 && dc_be_o == 0 && dc_wdata_o == 0 &&
            !out_valid_o && !out_misalign_o && !out_illegal_o && iq_ready_o,
            {dc_req_o, dc_we_o, dc_addr_o, dc_be_o, out_valid_o, iq_ready_o}, 128'(1));

        // Short post-reset traffic then drain
        issue(tbl[4]);
        issue(tbl[2]);
        repeat (LAT + 4) @(posedge clk); #1;
        chk("drain_empty", out_q.size() == 0 && dc_q.size() == 0,
            {64'(out_q.size()), 64'(dc_q.size())}, 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
